onehot_hold_decoder: RTL and testbench
======================================

# onehot_hold_decoder

Sequential 3-to-8 one-hot decoder: the receive-side counterpart of the 8-to-3 priority encoder. It accepts a binary index through a valid/ready handshake and drives the matching one-hot line for a programmable number of cycles. It then releases the line or chains directly to the next index. It sits after the encoder in the request/grant path and turns the encoded winner back into a per-line strobe.

## Interface
- `WIDTH_IN`, 3: index width; output width is `2**WIDTH_IN`.
- `HOLD`, 4: cycles each one-hot value is driven; legal range 1..255.
- `clk` in 1: rising-edge clock.
- `rst_n` in 1: reset, asynchronous, active-low.
- `in_valid` in 1: `in_code` is valid this cycle.
- `in_ready` out 1: block can accept an index this cycle.
- `in_code` in `WIDTH_IN`: binary index to decode.
- `y` out `2**WIDTH_IN`: one-hot output, registered.
- `y_valid` out 1: `y` currently carries a decoded value.
- `busy` out 1: the FSM is not in IDLE.

## Operation
- States: IDLE, DRIVE, and GAP. GAP exists only with `DEC_GAP_EN`.
- **Accept:** an index is accepted on a rising edge where `in_valid && in_ready`.
- **IDLE:**
  - `in_ready=1`, `y=0`, `y_valid=0`.
  - On accept: `y <= 1 << in_code`, load the hold counter with `HOLD-1`, go to DRIVE.
- **DRIVE:**
  - `y` is held, `y_valid=1`.
  - The counter decrements each cycle.
  - `in_ready=1` only in the last DRIVE cycle (counter == 0), and only without `DEC_GAP_EN`.
- **Last DRIVE cycle:**
  - With an accept: load the new one-hot, reload the counter, stay in DRIVE. This is the back-to-back case, with no zero cycle between values.
  - Without an accept: `y <= 0`, go to IDLE, or to GAP with the macro.
- **Index 0** decodes to `00000001`. The output is unambiguous, unlike the encoder's all-zero case, because `y_valid` qualifies `y`.
- **Ignored inputs:** `in_valid` while `in_ready=0` is ignored and not queued. The source must hold `in_valid` and `in_code` until the handshake completes.
- **`in_code` width:** any out-of-range bits are impossible, because the width is exact.
- **Reset assertion mid-operation:** immediately forces `y=0`, `y_valid=0`, `busy=0`, state IDLE, counter 0. The in-flight code is discarded.
- **Reset values:** `y=0`, `y_valid=0`, `busy=0`. `in_ready=1` once reset is released.
- **Invariant:** `y` is always zero or exactly one-hot.

## Timing
- Latency: accept at edge N; `y`/`y_valid` valid from edge N+1 through edge N+HOLD, i.e. exactly HOLD cycles.
- `HOLD=1`: one-cycle strobe. `in_ready` stays high throughout, so continuous streaming gives one decoded value per cycle.
- Without the macro, the sustained throughput is one index per HOLD cycles.
- `in_ready` is combinational from state and counter only, never from `in_valid`.
- `busy` equals (state != IDLE) and is registered-state derived.

## Configuration
- Macro: `DEC_GAP_EN`.
- **Defined:**
  - After every DRIVE period, one GAP cycle with `y=0`, `y_valid=0`, `in_ready=1`.
  - An accept in GAP goes to DRIVE; otherwise the FSM returns to IDLE.
  - Guarantees at least one zero cycle between consecutive one-hot values.
  - Sustained throughput is one index per HOLD+1 cycles.
- **Undefined:** the GAP state and its logic are absent, and back-to-back chaining from the last DRIVE cycle applies.

## Structure
- **Shared package `dec_pkg`:**
  - state enum: IDLE, DRIVE, GAP;
  - `HOLD_W = $clog2(HOLD+1)` helper;
  - one-hot width constant derivation.
- **Sub-module `hold_counter`:**
  - load/decrement down-counter with a `zero` flag;
  - parameterised by width;
  - reusable by other pulse-stretch blocks.

## Test plan
- **Reset:** assert `rst_n=0` mid-run → `y=00000000`, `y_valid=0`, `busy=0` immediately, without waiting for a clock edge. Release → `in_ready=1`.
- **Single decode:** `HOLD=4`, accept code 5 at edge N → `y=00100000`, `y_valid=1` for edges N+1..N+4. `y=0`, state IDLE at edge N+5.
- **Full sweep:** codes 0..7 one at a time → `y` goes `00000001`, `00000010`, … `10000000`, each value exactly one-hot for HOLD cycles.
- **Back-to-back (macro off):** `in_valid` held high with code 0, then code 7 → `00000001` for 4 cycles followed immediately by `10000000` for 4 cycles, with no zero cycle. Also check `HOLD=1` streaming at one value per cycle.
- **Gap (macro on):** same stimulus → `00000001` ×4, then `00000000` ×1 with `in_ready=1`, then `10000000` ×4.
- **Handshake stall:** `in_valid` toggled with changing codes while `in_ready=0` → `y` unchanged. Only codes presented while `in_ready=1` appear on the output.

Source files
------------

// File: rtl/dec_pkg.sv
// Shared definitions for the one-hot hold decoder family.
//   - FSM state encodings (IDLE, DRIVE, GAP)
//   - hold_w(): width of a down-counter that must reach HOLD-1
//   - onehot_w(): one-hot bus width for a given binary index width
package dec_pkg;

  localparam int unsigned ST_W = 2;

  localparam logic [ST_W-1:0] ST_IDLE  = 2'd0;
  localparam logic [ST_W-1:0] ST_DRIVE = 2'd1;
  localparam logic [ST_W-1:0] ST_GAP   = 2'd2;

  // Counter width able to hold HOLD-1; HOLD=1 still gets one bit.
  function automatic int unsigned hold_w(input int unsigned hold);
    return $clog2(hold + 1);
  endfunction

  function automatic int unsigned onehot_w(input int unsigned w_in);
    return 1 << w_in;
  endfunction

endpackage

// File: rtl/hold_counter.sv
// Load/decrement down-counter with a zero flag, for pulse-stretch blocks.
// Ports:
//   clk, rst_n : clock, async active-low reset (count cleared to 0)
//   load       : load load_val (has priority over dec)
//   load_val   : value to load
//   dec        : decrement by one; saturates at zero
//   zero       : count is zero (decoded from the count register)
module hold_counter #(
  parameter int unsigned W = 3
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         dec,
  output logic         zero
);

  logic [W-1:0] count;

  // Count register: load wins over decrement, decrement stops at zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (dec && (count != '0)) begin
      count <= count - W'(1);
    end
  end

  assign zero = (count == '0);

endmodule

// File: rtl/onehot_hold_decoder.sv
// Sequential 3-to-8 one-hot decoder with programmable hold time.
// Accepts a binary index over valid/ready and drives the matching one-hot
// line for HOLD cycles, then releases it or chains straight to the next index.
// Optional macro DEC_GAP_EN inserts one all-zero GAP cycle after every
// DRIVE period (no back-to-back chaining in that build).
// Ports:
//   clk, rst_n : clock, async active-low reset
//   in_valid   : in_code is valid
//   in_ready   : index can be accepted this cycle (from state/counter only)
//   in_code    : binary index
//   y          : registered one-hot output (zero or exactly one-hot)
//   y_valid    : y carries a decoded value
//   busy       : FSM is not in IDLE
module onehot_hold_decoder
  import dec_pkg::*;
#(
  parameter int unsigned WIDTH_IN = 3,
  parameter int unsigned HOLD     = 4
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [WIDTH_IN-1:0]       in_code,
  output logic [(2**WIDTH_IN)-1:0]  y,
  output logic                      y_valid,
  output logic                      busy
);

  localparam int unsigned OUT_W = onehot_w(WIDTH_IN);
  localparam int unsigned CNT_W = hold_w(HOLD);
  localparam logic [CNT_W-1:0] HOLD_LD = CNT_W'(HOLD - 1);

  logic [ST_W-1:0]  state;
  logic [ST_W-1:0]  state_nxt;
  logic [OUT_W-1:0] y_nxt;
  logic [OUT_W-1:0] code_oh;
  logic             cnt_load;
  logic             cnt_dec;
  logic             cnt_zero;

  assign code_oh = OUT_W'(1) << in_code;

  hold_counter #(
    .W (CNT_W)
  ) u_hold_counter (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (cnt_load),
    .load_val (HOLD_LD),
    .dec      (cnt_dec),
    .zero     (cnt_zero)
  );

  // Next-state, next-output and handshake logic.
  always_comb begin
    state_nxt = state;
    y_nxt     = y;
    cnt_load  = 1'b0;
    cnt_dec   = 1'b0;
    in_ready  = 1'b0;
    case (state)
      ST_IDLE: begin
        in_ready = 1'b1;
        y_nxt    = '0;
        if (in_valid) begin
          state_nxt = ST_DRIVE;
          y_nxt     = code_oh;
          cnt_load  = 1'b1;
        end
      end
      ST_DRIVE: begin
        if (!cnt_zero) begin
          cnt_dec = 1'b1;
        end else begin
`ifdef DEC_GAP_EN
          y_nxt     = '0;
          state_nxt = ST_GAP;
`else
          // Last DRIVE cycle: chain directly into the next index if offered.
          in_ready = 1'b1;
          if (in_valid) begin
            y_nxt    = code_oh;
            cnt_load = 1'b1;
          end else begin
            y_nxt     = '0;
            state_nxt = ST_IDLE;
          end
`endif
        end
      end
      ST_GAP: begin
        y_nxt     = '0;
        state_nxt = ST_IDLE;
`ifdef DEC_GAP_EN
        in_ready = 1'b1;
        if (in_valid) begin
          state_nxt = ST_DRIVE;
          y_nxt     = code_oh;
          cnt_load  = 1'b1;
        end
`endif
      end
      default: begin
        y_nxt     = '0;
        state_nxt = ST_IDLE;
      end
    endcase
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= ST_IDLE;
      y       <= '0;
      y_valid <= 1'b0;
    end else begin
      state   <= state_nxt;
      y       <= y_nxt;
      y_valid <= (state_nxt == ST_DRIVE);
    end
  end

  assign busy = (state != ST_IDLE);

endmodule

// File: tb/tb_onehot_hold_decoder.sv
// Directed bench for onehot_hold_decoder: HOLD=4 instance plus a HOLD=1
// instance for single-cycle streaming. Expectations follow DEC_GAP_EN.
module tb_onehot_hold_decoder;

`ifdef DEC_GAP_EN
  localparam bit GAP = 1'b1;
`else
  localparam bit GAP = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       in_valid = 1'b0;
  logic [2:0] in_code = '0;
  logic       in_ready;
  logic [7:0] y;
  logic       y_valid;
  logic       busy;

  logic       in_valid1 = 1'b0;
  logic [2:0] in_code1 = '0;
  logic       in_ready1;
  logic [7:0] y1;
  logic       y_valid1;
  logic       busy1;

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  onehot_hold_decoder #(.WIDTH_IN(3), .HOLD(4)) u_dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_code  (in_code),
    .y        (y),
    .y_valid  (y_valid),
    .busy     (busy)
  );

  onehot_hold_decoder #(.WIDTH_IN(3), .HOLD(1)) u_dut1 (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid1),
    .in_ready (in_ready1),
    .in_code  (in_code1),
    .y        (y1),
    .y_valid  (y_valid1),
    .busy     (busy1)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, "_y"}, 32'(y), 32'h0);
    chk({tag, "_yv"}, 32'(y_valid), 32'h0);
    chk({tag, "_busy"}, 32'(busy), 32'h0);
    chk({tag, "_rdy"}, 32'(in_ready), 32'h1);
  endtask

  // Present one code for a single cycle, then check the HOLD=4 window.
  task automatic decode_one(input logic [2:0] code);
    logic [7:0] e;
    e = 8'h01 << code;
    @(negedge clk);
    in_valid = 1'b1;
    in_code  = code;
    @(negedge clk);
    in_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if (i > 0) @(negedge clk);
      chk("dec_y", 32'(y), 32'(e));
      chk("dec_onehot", 32'($countones(y)), 32'd1);
      chk("dec_yv", 32'(y_valid), 32'h1);
      chk("dec_rdy", 32'(in_ready), 32'((i == 3) && !GAP));
    end
    @(negedge clk);
    chk("dec_after_y", 32'(y), 32'h0);
    chk("dec_after_yv", 32'(y_valid), 32'h0);
    if (GAP) begin
      chk("dec_gap_busy", 32'(busy), 32'h1);
      chk("dec_gap_rdy", 32'(in_ready), 32'h1);
      @(negedge clk);
    end
    chk("dec_after_busy", 32'(busy), 32'h0);
  endtask

  initial begin
    // Reset state
    #1;
    chk("rst_y", 32'(y), 32'h0);
    chk("rst_yv", 32'(y_valid), 32'h0);
    chk("rst_busy", 32'(busy), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk_idle("rel");

    // Single decode of code 5
    decode_one(3'd5);

    // Full sweep 0..7
    for (int c = 0; c < 8; c++) decode_one(3'(c));

    // Back-to-back: valid held high, code 0 then code 7
    @(negedge clk);
    in_valid = 1'b1;
    in_code  = 3'd0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      in_code = 3'd7;
      chk("b2b_y0", 32'(y), 32'h01);
    end
    if (GAP) begin
      @(negedge clk);
      chk("b2b_gap_y", 32'(y), 32'h0);
      chk("b2b_gap_yv", 32'(y_valid), 32'h0);
      chk("b2b_gap_rdy", 32'(in_ready), 32'h1);
    end
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      in_valid = 1'b0;
      chk("b2b_y7", 32'(y), 32'h80);
      chk("b2b_yv7", 32'(y_valid), 32'h1);
    end
    @(negedge clk);
    chk("b2b_end_y", 32'(y), 32'h0);
    if (GAP) @(negedge clk);
    chk("b2b_end_busy", 32'(busy), 32'h0);

    // Handshake stall: offers while in_ready=0 must be ignored
    @(negedge clk);
    in_valid = 1'b1;
    in_code  = 3'd2;
    @(negedge clk);
    chk("stall_y1", 32'(y), 32'h04);
    chk("stall_rdy1", 32'(in_ready), 32'h0);
    in_code = 3'd6;
    @(negedge clk);
    chk("stall_y2", 32'(y), 32'h04);
    chk("stall_rdy2", 32'(in_ready), 32'h0);
    in_valid = 1'b0;
    in_code  = 3'd1;
    @(negedge clk);
    chk("stall_y3", 32'(y), 32'h04);
    chk("stall_rdy3", 32'(in_ready), 32'h0);
    in_valid = 1'b1;
    in_code  = 3'd3;
    @(negedge clk);
    in_valid = 1'b0;
    chk("stall_y4", 32'(y), 32'h04);
    @(negedge clk);
    chk("stall_end_y", 32'(y), 32'h0);
    if (GAP) @(negedge clk);
    chk("stall_end_busy", 32'(busy), 32'h0);

    // HOLD=1 streaming on the second instance
    @(negedge clk);
    in_valid1 = 1'b1;
    in_code1  = 3'd3;
    @(negedge clk);
    chk("h1_y_a", 32'(y1), 32'h08);
    chk("h1_yv_a", 32'(y_valid1), 32'h1);
    chk("h1_rdy_a", 32'(in_ready1), 32'(!GAP));
    in_code1 = 3'd1;
    if (GAP) begin
      @(negedge clk);
      chk("h1_gap_a", 32'(y1), 32'h0);
      chk("h1_gap_rdy_a", 32'(in_ready1), 32'h1);
    end
    @(negedge clk);
    chk("h1_y_b", 32'(y1), 32'h02);
    in_code1 = 3'd6;
    if (GAP) begin
      @(negedge clk);
      chk("h1_gap_b", 32'(y1), 32'h0);
    end
    @(negedge clk);
    chk("h1_y_c", 32'(y1), 32'h40);
    in_valid1 = 1'b0;
    @(negedge clk);
    chk("h1_end_y", 32'(y1), 32'h0);
    chk("h1_end_yv", 32'(y_valid1), 32'h0);

    // Asynchronous reset in the middle of a DRIVE period
    @(negedge clk);
    in_valid = 1'b1;
    in_code  = 3'd4;
    @(negedge clk);
    in_valid = 1'b0;
    chk("mid_pre_y", 32'(y), 32'h10);
    #2;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_y", 32'(y), 32'h0);
    chk("mid_rst_yv", 32'(y_valid), 32'h0);
    chk("mid_rst_busy", 32'(busy), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk_idle("mid_rel");
    @(negedge clk);
    chk_idle("mid_settle");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
